// File: rtl/gate_resp_checker_if.sv
// Bus between a gate-stimulus source (master) and gate_resp_checker (slave).
// Signal suffixes are from the checker's point of view.
// Optional macro GATE_CHK_TIMEOUT_EN adds the timeout_o flag.
interface gate_resp_checker_if #(
  parameter int CNT_W = 16
);
  logic             start_i;
  logic [1:0]       op_i;
  logic [CNT_W-1:0] num_samples_i;
  logic             in_valid_i;
  logic             a_i;
  logic             b_i;
  logic             y_i;
  logic             busy_o;
  logic             done_o;
  logic             pass_o;
  logic             err_pulse_o;
  logic [CNT_W-1:0] err_cnt_o;
  logic [CNT_W-1:0] match_cnt_o;
  logic [CNT_W-1:0] first_err_idx_o;
  logic [2:0]       first_err_vec_o;
`ifdef GATE_CHK_TIMEOUT_EN
  logic             timeout_o;

  modport master (
    output start_i, op_i, num_samples_i, in_valid_i, a_i, b_i, y_i,
    input  busy_o, done_o, pass_o, err_pulse_o, err_cnt_o, match_cnt_o,
           first_err_idx_o, first_err_vec_o, timeout_o
  );
  modport slave (
    input  start_i, op_i, num_samples_i, in_valid_i, a_i, b_i, y_i,
    output busy_o, done_o, pass_o, err_pulse_o, err_cnt_o, match_cnt_o,
           first_err_idx_o, first_err_vec_o, timeout_o
  );
`else
  modport master (
    output start_i, op_i, num_samples_i, in_valid_i, a_i, b_i, y_i,
    input  busy_o, done_o, pass_o, err_pulse_o, err_cnt_o, match_cnt_o,
           first_err_idx_o, first_err_vec_o
  );
  modport slave (
    input  start_i, op_i, num_samples_i, in_valid_i, a_i, b_i, y_i,
    output busy_o, done_o, pass_o, err_pulse_o, err_cnt_o, match_cnt_o,
           first_err_idx_o, first_err_vec_o
  );
`endif
endinterface

// File: rtl/gate_resp_checker.sv
// Response checker for a two-input gate DUT. Computes the expected y for the
// selected gate, aligns it to the DUT latency through a LAT-deep delay line,
// counts matches/mismatches over a programmed run and captures the first error.
// Optional macro GATE_CHK_TIMEOUT_EN adds a 1000-cycle idle watchdog in RUN.
module gate_resp_checker #(
  parameter int CNT_W = 16,
  parameter int LAT   = 1
) (
  input  logic clk,
  input  logic rst,
  gate_resp_checker_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  typedef struct packed {
    logic             valid;
    logic             expv;
    logic             a;
    logic             b;
    logic [CNT_W-1:0] idx;
  } dl_entry_t;

  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [2:0]       DRAIN_INIT = 3'((LAT > 0) ? LAT - 1 : 0);

  state_t           state_q;
  logic [1:0]       op_q;
  logic [CNT_W-1:0] num_q, accept_cnt_q;
  logic [CNT_W-1:0] err_cnt_q, match_cnt_q, first_err_idx_q;
  logic [2:0]       first_err_vec_q, drain_cnt_q;
  logic             busy_q, done_q, pass_q, err_pulse_q;

  dl_entry_t        push_e, pop_e;
  logic             accept, last_accept, cmp_match, cmp_mismatch;
  logic             idle_expire, timeout_d;
  logic [CNT_W-1:0] err_cnt_d, match_cnt_d;

  function automatic logic gate_fn(input logic [1:0] op, input logic a, input logic b);
    case (op)
      2'd0:    return a & b;
      2'd1:    return a | b;
      2'd2:    return a ^ b;
      default: return ~(a & b);
    endcase
  endfunction

`ifdef GATE_CHK_TIMEOUT_EN
  logic [15:0] idle_cnt_q;
  logic        timeout_q;
  assign idle_expire = (state_q == S_RUN) && !bus.in_valid_i && (idle_cnt_q == 16'd999);
  assign timeout_d   = timeout_q | idle_expire;
  assign bus.timeout_o = timeout_q;

  // Idle watchdog: counts consecutive empty cycles while waiting for samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else if (bus.start_i && (state_q == S_IDLE || state_q == S_DONE)) begin
      idle_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else if (state_q == S_RUN) begin
      idle_cnt_q <= bus.in_valid_i ? 16'd0 : idle_cnt_q + 16'd1;
      if (idle_expire) timeout_q <= 1'b1;
    end
  end
`else
  assign idle_expire = 1'b0;
  assign timeout_d   = 1'b0;
`endif

  // Build the delay-line entry for this cycle and evaluate the outgoing entry.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // (which would infer a latch).
    accept       = (state_q == S_RUN) && bus.in_valid_i;
    last_accept  = accept && ((accept_cnt_q + CNT_W'(1)) == num_q);
    push_e.valid = accept;
    push_e.expv  = gate_fn(op_q, bus.a_i, bus.b_i);
    push_e.a     = bus.a_i;
    push_e.b     = bus.b_i;
    push_e.idx   = accept_cnt_q;
    cmp_match    = pop_e.valid && (pop_e.expv == bus.y_i);
    cmp_mismatch = pop_e.valid && (pop_e.expv != bus.y_i);
    err_cnt_d    = err_cnt_q;
    match_cnt_d  = match_cnt_q;
    if (cmp_mismatch && err_cnt_q != CNT_MAX) err_cnt_d = err_cnt_q + CNT_W'(1);
    if (cmp_match && match_cnt_q != CNT_MAX)  match_cnt_d = match_cnt_q + CNT_W'(1);
  end

  if (LAT == 0) begin : g_no_delay
    assign pop_e = push_e;
  end else begin : g_delay
    dl_entry_t dl_q [LAT];

    // Shift register aligning expected values with the DUT's y.
    always_ff @(posedge clk or posedge rst) begin
      // NOTE: this small array is reset so stale entries from an aborted run
      // can never be compared; large RAM-style arrays normally are not reset.
      if (rst) begin
        for (int i = 0; i < LAT; i++) dl_q[i] <= '0;
      end else begin
        dl_q[0] <= push_e;
        for (int i = 1; i < LAT; i++) dl_q[i] <= dl_q[i-1];
      end
    end

    assign pop_e = dl_q[LAT-1];
  end

  // Run-control FSM with registered outputs and result counters.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments throughout so every register samples
    // the pre-edge values, independent of statement order.
    if (rst) begin
      state_q         <= S_IDLE;
      op_q            <= '0;
      num_q           <= '0;
      accept_cnt_q    <= '0;
      err_cnt_q       <= '0;
      match_cnt_q     <= '0;
      first_err_idx_q <= '0;
      first_err_vec_q <= '0;
      drain_cnt_q     <= '0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      pass_q          <= 1'b0;
      err_pulse_q     <= 1'b0;
    end else begin
      done_q      <= 1'b0;
      err_pulse_q <= cmp_mismatch;
      err_cnt_q   <= err_cnt_d;
      match_cnt_q <= match_cnt_d;
      if (cmp_mismatch && err_cnt_q == '0) begin
        first_err_idx_q <= pop_e.idx;
        first_err_vec_q <= {pop_e.a, pop_e.b, bus.y_i};
      end
      if (accept) accept_cnt_q <= accept_cnt_q + CNT_W'(1);

      case (state_q)
        S_IDLE, S_DONE: begin
          if (bus.start_i) begin
            op_q            <= bus.op_i;
            num_q           <= bus.num_samples_i;
            accept_cnt_q    <= '0;
            err_cnt_q       <= '0;
            match_cnt_q     <= '0;
            first_err_idx_q <= '0;
            first_err_vec_q <= '0;
            pass_q          <= 1'b0;
            if (bus.num_samples_i == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              pass_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              state_q <= S_RUN;
              busy_q  <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (last_accept || idle_expire) begin
            drain_cnt_q <= DRAIN_INIT;
            if (LAT == 0) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= (err_cnt_d == '0) && !timeout_d;
            end else begin
              state_q <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (drain_cnt_q == '0) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_cnt_d == '0) && !timeout_d;
          end else begin
            drain_cnt_q <= drain_cnt_q - 3'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.busy_o          = busy_q;
  assign bus.done_o          = done_q;
  assign bus.pass_o          = pass_q;
  assign bus.err_pulse_o     = err_pulse_q;
  assign bus.err_cnt_o       = err_cnt_q;
  assign bus.match_cnt_o     = match_cnt_q;
  assign bus.first_err_idx_o = first_err_idx_q;
  assign bus.first_err_vec_o = first_err_vec_q;

endmodule

// File: doc/gate_resp_checker.md
Name: gate_resp_checker

Overview:
- Response-side counterpart to the two-input gate stimulus benches. It receives the (a, b) vectors applied to a gate DUT and the DUT's y output, and computes the expected result for a selected gate function.
- Compares expected against actual over a programmed number of samples, counts matches and mismatches, and captures the first failure.
- Synthesizable, so the same checker runs in simulation and on the FPGA board next to the gate under test.

Parameters:
- CNT_W, 16, width of the sample-count, match-count and error-count registers.
- LAT, 1, DUT output latency in clk cycles (0..7); 0 means y is checked in the same cycle as a/b.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a run when in IDLE or DONE.
- op  in  2  gate function, sampled at start: 0=AND, 1=OR, 2=XOR, 3=NAND.
- num_samples  in  CNT_W  number of valid samples to check, sampled at start.
- in_valid  in  1  a/b presented to the DUT this cycle.
- a  in  1  DUT input a.
- b  in  1  DUT input b.
- y  in  1  DUT output.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  one-cycle pulse on entry to DONE.
- pass  out  1  valid in DONE: 1 when err_cnt==0 (and no timeout).
- err_pulse  out  1  one-cycle pulse, registered, on each mismatch.
- err_cnt  out  CNT_W  mismatches in the current run, saturating.
- match_cnt  out  CNT_W  matches in the current run, saturating.
- first_err_idx  out  CNT_W  index (0-based) of the first mismatching sample.
- first_err_vec  out  3  {a, b, y} of the first mismatch.

Behaviour:
- Reset (asynchronous, clk-independent):
  - state=IDLE.
  - busy=0, done=0, pass=0, err_pulse=0.
  - err_cnt=0, match_cnt=0, first_err_idx=0, first_err_vec=0.
  - Delay line cleared.
  - Reset asserted mid-run aborts the run immediately; no done pulse is issued.
- States:
  - IDLE: waits for start.
  - RUN: accepts samples.
  - DRAIN: waits LAT cycles for the last in-flight sample.
  - DONE: results held.
- Start handling:
  - start in IDLE or DONE: latch op and num_samples, clear counters/capture/pass, accept_cnt=0.
  - Next state is RUN, or DONE directly if num_samples==0. In that case done pulses the next cycle with pass=1.
  - start in RUN or DRAIN is ignored.
- Sampling in RUN:
  - Each cycle with in_valid=1, compute exp = f(op, a, b) and push {valid, exp, a, b, idx=accept_cnt} into a LAT-deep delay line; accept_cnt increments.
  - in_valid=0 pushes an invalid bubble.
  - in_valid is ignored outside RUN.
- Comparison:
  - When a valid entry leaves the delay line, compare it with the current y.
  - Equal: match_cnt+1.
  - Unequal: err_cnt+1, and err_pulse is high the following cycle.
  - On the first mismatch only, first_err_idx and first_err_vec are captured.
- Saturation: counters saturate at 2^CNT_W-1 and never wrap.
- Run completion:
  - When accept_cnt reaches num_samples (the cycle of the last accept), RUN→DRAIN.
  - DRAIN lasts exactly LAT cycles, then →DONE.
  - With LAT=0, RUN→DONE directly.
- DONE: done=1 for exactly one cycle; pass = (err_cnt==0) registered at DONE entry. The state holds until start or rst.
- Latency:
  - Sample-to-verdict latency is LAT cycles.
  - done rises LAT+1 cycles after the final accepted in_valid.
- Simultaneous events:
  - The last accept and a delayed compare in the same cycle are both processed.
  - A mismatch on the final drained sample is counted before pass is computed.

Optional Feature:
- Macro GATE_CHK_TIMEOUT_EN.
- Defined:
  - Adds a 16-bit idle watchdog in RUN that counts consecutive cycles with in_valid=0 and resets on any in_valid.
  - At 1000 idle cycles: transition to DRAIN, set output timeout=1 (extra port); pass is forced to 0 in DONE.
  - timeout clears on start or rst.
- Not defined: no watchdog and no timeout port; RUN waits indefinitely for samples.

Test Plan:
- rst pulsed asynchronously mid-RUN after 5 samples -> all outputs 0 within the same cycle, state IDLE, no done pulse.
- op=AND, num_samples=4, LAT=1, ideal AND model, vectors 00,01,10,11 -> done 2 cycles after 4th in_valid, match_cnt=4, err_cnt=0, pass=1.
- op=AND, DUT stuck-at-1 on y, vectors 00,01,10,11 -> err_cnt=3, match_cnt=1, first_err_idx=0, first_err_vec=3'b001, three err_pulse pulses, pass=0.
- op=XOR, num_samples=100, 100 random vectors with in_valid gaps, ideal XOR DUT -> match_cnt=100, pass=1; a start issued during RUN is ignored.
- num_samples=0 then start -> done the cycle after start, pass=1, counters 0; a second start with num_samples=2 restarts from cleared counters.
- GATE_CHK_TIMEOUT_EN defined, num_samples=10, only 3 samples then in_valid=0 -> after 1000 idle cycles timeout=1, done pulse, pass=0, match_cnt=3.
